// File: rtl/axi4lite_slave_regs_if.sv
// AXI4-Lite bus bundle shared by the register slave and whatever master sits
// opposite it. Clock and reset are plain ports on the modules.
//   AW channel : S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_AWREADY
//   W  channel : S_AXI_WDATA,  S_AXI_WSTRB,  S_AXI_WVALID,  S_AXI_WREADY
//   B  channel : S_AXI_BRESP,  S_AXI_BVALID, S_AXI_BREADY
//   AR channel : S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_ARREADY
//   R  channel : S_AXI_RDATA,  S_AXI_RRESP,  S_AXI_RVALID,  S_AXI_RREADY
interface axi4lite_slave_regs_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave holding a bank of 32-bit control/status registers, exposed
// flat on regs_out (reg k at bits [32k+31:32k]). Write and read channels run
// independent FSMs; every READY/VALID output is a flop.
// Ports:
//   S_AXI_ACLK    clock, rising edge
//   S_AXI_ARESETN async active-low reset
//   s_axi         AXI4-Lite bus (slave modport)
//   regs_out      register bank contents
//
// Write FSM
//   state       | meaning
//   W_IDLE      | waiting for AW and/or W (AWREADY=1, WREADY=1)
//   W_HAVE_ADDR | address latched, waiting for W (WREADY=1)
//   W_HAVE_DATA | data/strobe latched, waiting for AW (AWREADY=1)
//   W_RESP      | response pending (BVALID=1) until BREADY
// Read FSM
//   state       | meaning
//   R_IDLE      | waiting for AR (ARREADY=1)
//   R_DATA      | read data held (RVALID=1) until RREADY
module axi4lite_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_S_AXI_NUM_REGS   = 4
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESETN,
  axi4lite_slave_regs_if.slave s_axi,
  output logic [C_S_AXI_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int NR    = C_S_AXI_NUM_REGS;
  localparam int SW    = DW / 8;
  localparam int IDX_W = AW - 2;
  localparam logic [IDX_W:0] NR_W = (IDX_W+1)'(NR);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DW-1:0] r_regs [NR];

  // ---------------- write channel ----------------
  w_state_t      r_wstate, w_wstate_nxt;
  logic          r_awready, r_wready, r_bvalid;
  logic [1:0]    r_bresp;
  logic [AW-1:0] r_awaddr;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;

  logic             w_aw_hs, w_w_hs;
  logic             w_commit, w_latch_addr, w_latch_data;
  logic [AW-1:0]    w_wr_addr;
  logic [DW-1:0]    w_wr_data;
  logic [SW-1:0]    w_wr_strb;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_wr_in_range;

  assign w_aw_hs = s_axi.S_AXI_AWVALID & r_awready;
  assign w_w_hs  = s_axi.S_AXI_WVALID  & r_wready;

  // Whichever half arrived earlier comes from the latch, the other is live.
  assign w_wr_addr     = (r_wstate == W_HAVE_ADDR) ? r_awaddr : s_axi.S_AXI_AWADDR;
  assign w_wr_data     = (r_wstate == W_HAVE_DATA) ? r_wdata  : s_axi.S_AXI_WDATA;
  assign w_wr_strb     = (r_wstate == W_HAVE_DATA) ? r_wstrb  : s_axi.S_AXI_WSTRB;
  assign w_wr_idx      = w_wr_addr[AW-1:2];
  assign w_wr_in_range = ({1'b0, w_wr_idx} < NR_W);

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    w_latch_addr = 1'b0;
    w_latch_data = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end else if (w_aw_hs) begin
          w_latch_addr = 1'b1;
          w_wstate_nxt = W_HAVE_ADDR;
        end else if (w_w_hs) begin
          w_latch_data = 1'b1;
          w_wstate_nxt = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_w_hs) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        if (w_aw_hs) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Ready/valid flops are decoded from the next state so they line up with
  // the state they describe.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_DATA);
      r_wready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_ADDR);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      if (w_commit)     r_bresp  <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
      if (w_latch_addr) r_awaddr <= s_axi.S_AXI_AWADDR;
      if (w_latch_data) begin
        r_wdata <= s_axi.S_AXI_WDATA;
        r_wstrb <= s_axi.S_AXI_WSTRB;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int k = 0; k < NR; k++) r_regs[k] <= '0;
    end else if (w_commit && w_wr_in_range) begin
      for (int k = 0; k < NR; k++) begin
        if (w_wr_idx == IDX_W'(k)) begin
          for (int b = 0; b < SW; b++) begin
            if (w_wr_strb[b]) r_regs[k][8*b +: 8] <= w_wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t      r_rstate, w_rstate_nxt;
  logic          r_arready, r_rvalid;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_rresp;

  logic             w_ar_hs;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_rd_in_range;
  logic [DW-1:0]    w_rd_data;

  assign w_ar_hs       = s_axi.S_AXI_ARVALID & r_arready;
  assign w_rd_idx      = s_axi.S_AXI_ARADDR[AW-1:2];
  assign w_rd_in_range = ({1'b0, w_rd_idx} < NR_W);

  // Loop mux keeps out-of-range indices from addressing past the array.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NR; k++) begin
      if (w_rd_idx == IDX_W'(k)) w_rd_data = r_regs[k];
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi.S_AXI_RREADY) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // RDATA samples the bank before any same-edge write lands.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
      if (r_rstate == R_IDLE && w_ar_hs) begin
        r_rdata <= w_rd_in_range ? w_rd_data : '0;
        r_rresp <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // ---------------- outputs ----------------
  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;

  for (genvar k = 0; k < NR; k++) begin : g_regs_out
    assign regs_out[DW*k +: DW] = r_regs[k];
  end

  // Protection bits and the byte offset within a word carry no meaning here.
  logic w_unused;
  assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                      w_wr_addr[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
module tb_axi4lite_slave_regs;

  logic        clk;
  logic        rst_n;
  logic [95:0] regs_out;

  int checks;
  int failures;

  axi4lite_slave_regs_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  axi4lite_slave_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .C_S_AXI_NUM_REGS  (3)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi        (bus),
    .regs_out     (regs_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [3:0]  raddr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    n = 0;
    while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wr_ready_wait", (n < 20), 1);
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    chk("wr_bvalid_latency", bus.S_AXI_BVALID, 1);
    resp = bus.S_AXI_BRESP;
    @(negedge clk);
    chk("wr_bvalid_clear", bus.S_AXI_BVALID, 0);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_ready_wait", (n < 20), 1);
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    chk("rd_rvalid_latency", bus.S_AXI_RVALID, 1);
    d    = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    @(negedge clk);
    chk("rd_rvalid_clear", bus.S_AXI_RVALID, 0);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [1:0]  rresp;
    logic [31:0] rdata;

    checks   = 0;
    failures = 0;

    // Cumulative from reset with NUM_REGS=3 (index 3 = address 0xC out of range).
    vecs[0] = '{4'h4, 32'hDEADBEEF, 4'hF, 2'b00, 4'h4, 32'hDEADBEEF, 2'b00};
    vecs[1] = '{4'h0, 32'hFFFFFFFF, 4'hF, 2'b00, 4'h0, 32'hFFFFFFFF, 2'b00};
    vecs[2] = '{4'h0, 32'h00000000, 4'h5, 2'b00, 4'h0, 32'hFF00FF00, 2'b00};
    vecs[3] = '{4'h0, 32'h12345678, 4'h0, 2'b00, 4'h0, 32'hFF00FF00, 2'b00};
    vecs[4] = '{4'hC, 32'hAAAAAAAA, 4'hF, 2'b10, 4'hC, 32'h00000000, 2'b10};
    vecs[5] = '{4'h9, 32'hCAFEF00D, 4'hA, 2'b00, 4'hA, 32'hCA00F000, 2'b00};
    vecs[6] = '{4'h5, 32'h11223344, 4'h2, 2'b00, 4'h4, 32'hDEAD33EF, 2'b00};

    rst_n = 1'b0;
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWPROT  = 3'b000;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARPROT  = 3'b000;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;

    // Reset and release
    repeat (3) @(negedge clk);
    chk("rst_awready", bus.S_AXI_AWREADY, 0);
    chk("rst_bvalid", bus.S_AXI_BVALID, 0);
    chk("rst_regs", regs_out, 96'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_awready_before_edge", bus.S_AXI_AWREADY, 0);
    @(negedge clk);
    chk("rel_awready", bus.S_AXI_AWREADY, 1);
    chk("rel_wready", bus.S_AXI_WREADY, 1);
    chk("rel_arready", bus.S_AXI_ARREADY, 1);
    chk("rel_bvalid", bus.S_AXI_BVALID, 0);
    chk("rel_rvalid", bus.S_AXI_RVALID, 0);
    chk("rel_regs", regs_out, 96'h0);

    // Table: simultaneous AW+W write, then read-back
    for (int i = 0; i < 7; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
      chk($sformatf("vec%0d_bresp", i), resp, vecs[i].bresp);
      axi_read(vecs[i].raddr, rdata, rresp);
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
      chk($sformatf("vec%0d_rresp", i), rresp, vecs[i].rresp);
    end
    chk("table_regs_out", regs_out, {32'hCA00F000, 32'hDEAD33EF, 32'hFF00FF00});

    // W three cycles ahead of AW
    @(negedge clk);
    bus.S_AXI_WDATA  = 32'h12345678;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_WDATA  = 32'h0;
    bus.S_AXI_WSTRB  = 4'h0;
    chk("wfirst_wready_low", bus.S_AXI_WREADY, 0);
    chk("wfirst_awready_high", bus.S_AXI_AWREADY, 1);
    repeat (2) @(negedge clk);
    chk("wfirst_no_early_commit", regs_out[95:64], 32'hCA00F000);
    chk("wfirst_no_early_bvalid", bus.S_AXI_BVALID, 0);
    bus.S_AXI_AWADDR  = 4'h8;
    bus.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    chk("wfirst_bvalid", bus.S_AXI_BVALID, 1);
    chk("wfirst_bresp", bus.S_AXI_BRESP, 2'b00);
    chk("wfirst_reg2", regs_out[95:64], 32'h12345678);
    @(negedge clk);

    // AW ahead of W
    bus.S_AXI_AWADDR  = 4'h4;
    bus.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_AWADDR  = 4'hC;
    chk("afirst_awready_low", bus.S_AXI_AWREADY, 0);
    chk("afirst_wready_high", bus.S_AXI_WREADY, 1);
    @(negedge clk);
    bus.S_AXI_WDATA  = 32'h0BADF00D;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_WVALID = 1'b0;
    chk("afirst_bvalid", bus.S_AXI_BVALID, 1);
    chk("afirst_bresp", bus.S_AXI_BRESP, 2'b00);
    chk("afirst_reg1", regs_out[63:32], 32'h0BADF00D);
    @(negedge clk);

    // Same-cycle read and write of reg0: read sees the old value
    bus.S_AXI_AWADDR  = 4'h0;
    bus.S_AXI_WDATA   = 32'h11111111;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_ARADDR  = 4'h0;
    bus.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    chk("rw_same_rvalid", bus.S_AXI_RVALID, 1);
    chk("rw_same_rdata_old", bus.S_AXI_RDATA, 32'hFF00FF00);
    chk("rw_same_bvalid", bus.S_AXI_BVALID, 1);
    chk("rw_same_reg0_new", regs_out[31:0], 32'h11111111);
    @(negedge clk);

    // Backpressure on both channels, then async reset mid-stall
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;
    bus.S_AXI_AWADDR  = 4'h0;
    bus.S_AXI_WDATA   = 32'h00000055;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_ARADDR  = 4'h8;
    bus.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_AWADDR  = 4'h4;
    bus.S_AXI_WDATA   = 32'hFFFFFFFF;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_bvalid", c), bus.S_AXI_BVALID, 1);
      chk($sformatf("stall%0d_bresp", c), bus.S_AXI_BRESP, 2'b00);
      chk($sformatf("stall%0d_rvalid", c), bus.S_AXI_RVALID, 1);
      chk($sformatf("stall%0d_rdata", c), bus.S_AXI_RDATA, 32'h12345678);
      chk($sformatf("stall%0d_awready", c), bus.S_AXI_AWREADY, 0);
      @(negedge clk);
    end
    chk("stall_reg1_untouched", regs_out[63:32], 32'h0BADF00D);
    chk("stall_reg0_committed", regs_out[31:0], 32'h00000055);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_bvalid", bus.S_AXI_BVALID, 0);
    chk("async_rst_rvalid", bus.S_AXI_RVALID, 0);
    chk("async_rst_rdata", bus.S_AXI_RDATA, 32'h0);
    chk("async_rst_awready", bus.S_AXI_AWREADY, 0);
    chk("async_rst_regs", regs_out, 96'h0);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_bvalid", bus.S_AXI_BVALID, 0);
    axi_read(4'h0, rdata, rresp);
    chk("post_rst_rdata", rdata, 32'h0);
    chk("post_rst_rresp", rresp, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4lite_slave_regs.md
Name: axi4lite_slave_regs

Overview:
AXI4-Lite slave (responder) holding a small bank of 32-bit control/status registers. It sits opposite Master_AXI4Lite on the same bus and accepts its write and read transactions. It returns OKAY/SLVERR responses and exposes the register contents as a flat output bus to fabric logic. Write and read channels run independent state machines.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width in bits; 32 only.
C_S_AXI_ADDR_WIDTH, 4, byte address width.
C_S_AXI_NUM_REGS, 4, number of implemented registers; 1..2^(ADDR_WIDTH-2).

Ports:
S_AXI_ACLK  in  1  clock; all logic on the rising edge.
S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
S_AXI_AWADDR  in  ADDR_WIDTH  write byte address.
S_AXI_AWPROT  in  3  write protection; ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  DATA_WIDTH  write data.
S_AXI_WSTRB  in  DATA_WIDTH/8  byte-lane write enables.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  ADDR_WIDTH  read byte address.
S_AXI_ARPROT  in  3  read protection; ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  DATA_WIDTH  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
regs_out  out  NUM_REGS*DATA_WIDTH  register bank contents; reg k at bits [32k+31:32k].

Behaviour:
- Reset (ARESETN low, asynchronous): all outputs 0, all registers 0, both FSMs in IDLE.
- All *READY/*VALID outputs are flops. AWREADY, WREADY and ARREADY go to 1 on the first rising edge after reset release.
- Decode: index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. Index >= NUM_REGS is out of range.
- Write FSM states: W_IDLE (AWREADY=1, WREADY=1), W_HAVE_ADDR (AWREADY=0, WREADY=1), W_HAVE_DATA (AWREADY=1, WREADY=0), W_RESP (both 0, BVALID=1).
- W_IDLE transitions:
  - AWVALID&WVALID: commit, go to W_RESP.
  - AWVALID only: latch AWADDR, go to W_HAVE_ADDR.
  - WVALID only: latch WDATA/WSTRB, go to W_HAVE_DATA.
- W_HAVE_ADDR: on WVALID, commit and go to W_RESP. W_HAVE_DATA: on AWVALID, commit and go to W_RESP.
- W_RESP: on BREADY, BVALID<=0 and return to W_IDLE. BRESP is held stable while BVALID=1.
- Commit occurs at the completing handshake edge:
  - In range: byte lane i of the register is updated iff WSTRB[i]. BRESP=2'b00.
  - Out of range: no register changes, BRESP=2'b10.
  - WSTRB=0: no change, OKAY.
  - New value is visible on regs_out and to reads from the next cycle.
- Minimum write cost is 2 cycles (handshake, then BVALID cycle), assuming BREADY is already high.
- Read FSM states: R_IDLE (ARREADY=1) and R_DATA (RVALID=1).
  - R_IDLE: on ARVALID, ARREADY<=0, RVALID<=1, RDATA<=reg[index] (0 if out of range), RRESP<=00 or 10. Go to R_DATA.
  - R_DATA: RDATA and RRESP are held stable. On RREADY, RVALID<=0, ARREADY<=1, return to R_IDLE.
- Read latency: RVALID rises 1 cycle after the AR handshake.
- Simultaneous read and write commit to the same register in the same cycle: the read returns the pre-write value.
- Write and read channels never stall each other.
- Reset asserted mid-transaction: everything clears immediately. No pending response survives reset. Registers return to 0.
- Master backpressure (BREADY or RREADY held low) holds the FSM in W_RESP or R_DATA indefinitely. No further transactions are accepted on that channel meanwhile.

Test Plan:
- Reset then idle: after release, AWREADY=WREADY=ARREADY=1 one cycle later. BVALID=RVALID=0 and regs_out=0.
- AW+W same cycle, addr 0x4, data 0xDEADBEEF, WSTRB=F, BREADY=1 -> BVALID the next cycle with BRESP=00. Read 0x4 -> RDATA=0xDEADBEEF, RRESP=00, RVALID 1 cycle after AR.
- W three cycles before AW (addr 0x8, data 0x12345678) -> WREADY drops after W, AWREADY stays 1. Commit on AW, reg2=0x12345678. Repeat with AW first.
- Partial strobe: reg0=0xFFFFFFFF, write 0x00000000 with WSTRB=0101 -> reg0=0xFF00FF00. WSTRB=0000 -> unchanged, BRESP=00.
- NUM_REGS=3, write/read 0xC -> BRESP=10, RRESP=10, RDATA=0, no register modified.
- BREADY/RREADY held low 5 cycles -> BVALID/RVALID, BRESP, RDATA stable. A new AWVALID is not accepted. Async reset during the stall -> outputs 0 without a clock edge.
